md_issue_ctrl: RTL and testbench

Sequencing controller for RV32M/RV64M multiply/divide, sitting beside the main decoder in the D stage of the 5-stage pipeline. It classifies M-extension ops, issues one-cycle start pulses to the multiplier/divider, and tracks the single outstanding op and its destination. It stalls D on structural and RAW hazards against that op and presents a one-cycle writeback pulse. It generalises the combinational M-op decode with XLEN-dependent W-op support, busy tracking, hazard stalls and a stall counter.

---
 rtl/md_issue_pkg.sv | 57 +++++
 rtl/md_op_decode.sv | 38 +++
 rtl/md_issue_ctrl.sv | 159 +++++++++++++++
 tb/tb_md_issue_ctrl.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_issue_pkg.sv
// Shared types and encodings for the M-extension issue controller and its decoder.
// Feature macro MD_DIV0_FASTPATH_EN is consumed by md_issue_ctrl, not by this package.
package md_issue_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    MUL_WAIT = 3'd2,
    DIV_WAIT = 3'd3,
    WB       = 3'd4
  } md_state_e;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [1:0] MF_MUL    = 2'b00;
  localparam logic [1:0] MF_MULH   = 2'b01;
  localparam logic [1:0] MF_MULHU  = 2'b10;
  localparam logic [1:0] MF_MULHSU = 2'b11;

  localparam logic [1:0] DF_DIV  = 2'b00;
  localparam logic [1:0] DF_DIVU = 2'b01;
  localparam logic [1:0] DF_REM  = 2'b10;
  localparam logic [1:0] DF_REMU = 2'b11;

  // Everything about the outstanding op that must survive until writeback.
  typedef struct packed {
    logic       is_div;
    logic [1:0] func;
    logic       word_op;
  } md_op_t;

  // funct3 ordering of the multiplier ops differs from the unit's func code.
  function automatic logic [1:0] mult_func_enc(input logic [2:0] funct3);
    logic [1:0] enc;
    case (funct3[1:0])
      2'b00:   enc = MF_MUL;
      2'b01:   enc = MF_MULH;
      2'b10:   enc = MF_MULHSU;
      default: enc = MF_MULHU;
    endcase
    return enc;
  endfunction

  function automatic logic [1:0] div_func_enc(input logic [2:0] funct3);
    logic [1:0] enc;
    case (funct3[1:0])
      2'b00:   enc = DF_DIV;
      2'b01:   enc = DF_DIVU;
      2'b10:   enc = DF_REM;
      default: enc = DF_REMU;
    endcase
    return enc;
  endfunction

endpackage

// File: rtl/md_op_decode.sv
// Combinational M-extension classifier: opcode/funct3/funct7 to is_md, is_div, func, word_op.
// W-ops (opcode 0111011) are only recognised when XLEN is 64.
module md_op_decode
  import md_issue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       is_md,
  output logic       is_div,
  output logic [1:0] func,
  output logic       word_op
);

  always_comb begin
    is_md   = 1'b0;
    word_op = 1'b0;
    is_div  = funct3[2];
    func    = funct3[2] ? div_func_enc(funct3) : mult_func_enc(funct3);
    if (funct7 == FUNCT7_MULDIV) begin
      if (opcode == OPC_OP) begin
        is_md = 1'b1;
      end else if ((XLEN == 64) && (opcode == OPC_OP_32)) begin
        // Only mulw and the four divide/remainder W forms exist.
        case (funct3)
          3'b000, 3'b100, 3'b101, 3'b110, 3'b111: begin
            is_md   = 1'b1;
            word_op = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue/sequencing controller for the single outstanding multiply/divide op in D.
// Optional feature macro: MD_DIV0_FASTPATH_EN (divide-by-zero answered without the divider).
module md_issue_ctrl
  import md_issue_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      instr_valid_D,
  input  logic                      flush_D,
  input  logic [6:0]                opcode_D,
  input  logic [2:0]                funct3_D,
  input  logic [6:0]                funct7_D,
  input  logic [REG_ADDR_WIDTH-1:0] rd_D,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_D,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_D,
  input  logic [XLEN-1:0]           rs1_val_E,
  input  logic [XLEN-1:0]           rs2_val_E,
  input  logic                      mult_done,
  input  logic                      div_done,
  output logic                      start_mult,
  output logic                      start_div,
  output logic [1:0]                mult_func,
  output logic [1:0]                div_func,
  output logic                      word_op,
  output logic                      md_busy,
  output logic                      stall_D,
  output logic                      md_wb_valid,
  output logic [REG_ADDR_WIDTH-1:0] md_wb_rd,
  output logic                      md_dz_valid,
  output logic [XLEN-1:0]           md_dz_result,
  output logic [CNT_WIDTH-1:0]      md_stall_cnt
);

  md_state_e                 state;
  md_op_t                    op_q;
  logic [REG_ADDR_WIDTH-1:0] md_rd;

  logic       dec_is_md;
  logic       dec_is_div;
  logic [1:0] dec_func;
  logic       dec_word_op;

  logic accept;
  logic raw_hit;
  logic div_zero;
  logic in_issue;
  logic in_wb;

  md_op_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .opcode (opcode_D),
    .funct3 (funct3_D),
    .funct7 (funct7_D),
    .is_md  (dec_is_md),
    .is_div (dec_is_div),
    .func   (dec_func),
    .word_op(dec_word_op)
  );

  assign in_issue = (state == ISSUE);
  assign in_wb    = (state == WB);
  assign md_busy  = (state != IDLE);

  // In WB the result is already on the writeback path, so RAW against it clears a cycle early.
  assign raw_hit = (md_rd != '0) && ((rs1_D == md_rd) || (rs2_D == md_rd)) && !in_wb;
  assign stall_D = instr_valid_D && md_busy && (dec_is_md || raw_hit);
  assign accept  = instr_valid_D && dec_is_md && !flush_D && !stall_D && (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= '0;
      md_rd <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state        <= ISSUE;
            op_q.is_div  <= dec_is_div;
            op_q.func    <= dec_func;
            op_q.word_op <= dec_word_op;
            md_rd        <= rd_D;
          end
        end
        ISSUE: begin
          if (op_q.is_div && div_zero) begin
            state <= WB;
          end else if (op_q.is_div) begin
            state <= DIV_WAIT;
          end else begin
            state <= MUL_WAIT;
          end
        end
        MUL_WAIT: if (mult_done) state <= WB;
        DIV_WAIT: if (div_done) state <= WB;
        WB:       state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  assign start_mult  = in_issue && !op_q.is_div;
  assign start_div   = in_issue && op_q.is_div && !div_zero;
  assign mult_func   = (md_busy && !op_q.is_div) ? op_q.func : 2'b00;
  assign div_func    = (md_busy && op_q.is_div) ? op_q.func : 2'b00;
  assign word_op     = md_busy && op_q.word_op;
  assign md_wb_valid = in_wb;
  assign md_wb_rd    = in_wb ? md_rd : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_stall_cnt <= '0;
    end else if (stall_D && (md_stall_cnt != '1)) begin
      md_stall_cnt <= md_stall_cnt + CNT_WIDTH'(1);
    end
  end

`ifdef MD_DIV0_FASTPATH_EN
  logic            dz_q;
  logic [XLEN-1:0] dz_result_q;
  logic [XLEN-1:0] rem_result;

  // Remainder by zero returns the dividend; W forms sign-extend its low word.
  always_comb begin
    div_zero   = op_q.word_op ? (rs2_val_E[31:0] == 32'd0) : (rs2_val_E == '0);
    rem_result = rs1_val_E;
    if (op_q.word_op) begin
      rem_result       = {XLEN{rs1_val_E[31]}};
      rem_result[31:0] = rs1_val_E[31:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dz_q        <= 1'b0;
      dz_result_q <= '0;
    end else if (in_issue) begin
      dz_q        <= op_q.is_div && div_zero;
      dz_result_q <= op_q.func[1] ? rem_result : '1;
    end
  end

  assign md_dz_valid  = in_wb && dz_q;
  assign md_dz_result = md_dz_valid ? dz_result_q : '0;
`else
  logic unused_operands;

  assign div_zero        = 1'b0;
  assign md_dz_valid     = 1'b0;
  assign md_dz_result    = '0;
  assign unused_operands = ^{rs1_val_E, rs2_val_E};
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: decode table, directed corner sequences, random vs model.
// Expectations follow MD_DIV0_FASTPATH_EN when it is defined for the build.
module tb_md_issue_ctrl;

  localparam int XLEN = 64;
  localparam int RW   = 5;
  localparam int CW   = 32;
  localparam logic [6:0] OPC   = 7'b0110011;
  localparam logic [6:0] OPC32 = 7'b0111011;
  localparam logic [6:0] F7M   = 7'b0000001;

  logic clk = 1'b0;
  logic rst;
  logic instr_valid_D, flush_D;
  logic [6:0] opcode_D, funct7_D;
  logic [2:0] funct3_D;
  logic [RW-1:0] rd_D, rs1_D, rs2_D;
  logic [63:0] rs1_val_E, rs2_val_E;
  logic mult_done, div_done;

  logic start_mult, start_div, word_op, md_busy, stall_D, md_wb_valid, md_dz_valid;
  logic [1:0] mult_func, div_func;
  logic [RW-1:0] md_wb_rd;
  logic [63:0] md_dz_result;
  logic [CW-1:0] md_stall_cnt;

  logic b_start_mult, b_start_div, b_word_op, b_md_busy, b_stall_D, b_md_wb_valid, b_md_dz_valid;
  logic [1:0] b_mult_func, b_div_func;
  logic [RW-1:0] b_md_wb_rd;
  logic [31:0] b_md_dz_result;
  logic [CW-1:0] b_md_stall_cnt;

  int checks;
  int fails;

  always #5 clk = ~clk;

  md_issue_ctrl #(.XLEN(XLEN), .REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)) u_dut (
    .clk(clk), .rst(rst), .instr_valid_D(instr_valid_D), .flush_D(flush_D),
    .opcode_D(opcode_D), .funct3_D(funct3_D), .funct7_D(funct7_D),
    .rd_D(rd_D), .rs1_D(rs1_D), .rs2_D(rs2_D),
    .rs1_val_E(rs1_val_E), .rs2_val_E(rs2_val_E),
    .mult_done(mult_done), .div_done(div_done),
    .start_mult(start_mult), .start_div(start_div), .mult_func(mult_func), .div_func(div_func),
    .word_op(word_op), .md_busy(md_busy), .stall_D(stall_D), .md_wb_valid(md_wb_valid),
    .md_wb_rd(md_wb_rd), .md_dz_valid(md_dz_valid), .md_dz_result(md_dz_result),
    .md_stall_cnt(md_stall_cnt)
  );

  md_issue_ctrl #(.XLEN(32), .REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)) u_dut32 (
    .clk(clk), .rst(rst), .instr_valid_D(instr_valid_D), .flush_D(flush_D),
    .opcode_D(opcode_D), .funct3_D(funct3_D), .funct7_D(funct7_D),
    .rd_D(rd_D), .rs1_D(rs1_D), .rs2_D(rs2_D),
    .rs1_val_E(rs1_val_E[31:0]), .rs2_val_E(rs2_val_E[31:0]),
    .mult_done(mult_done), .div_done(div_done),
    .start_mult(b_start_mult), .start_div(b_start_div), .mult_func(b_mult_func), .div_func(b_div_func),
    .word_op(b_word_op), .md_busy(b_md_busy), .stall_D(b_stall_D), .md_wb_valid(b_md_wb_valid),
    .md_wb_rd(b_md_wb_rd), .md_dz_valid(b_md_dz_valid), .md_dz_result(b_md_dz_result),
    .md_stall_cnt(b_md_stall_cnt)
  );

  typedef struct {
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       flush;
    logic       md64;
    logic       md32;
    logic       dv;
    logic [1:0] fn;
    logic       word;
  } vec_t;

  task automatic applyStimulus(input logic v, input logic fl, input logic [6:0] opc,
                               input logic [2:0] f3, input logic [6:0] f7,
                               input logic [RW-1:0] rd, input logic [RW-1:0] rs1,
                               input logic [RW-1:0] rs2, input logic md, input logic dd);
    instr_valid_D = v;
    flush_D       = fl;
    opcode_D      = opc;
    funct3_D      = f3;
    funct7_D      = f7;
    rd_D          = rd;
    rs1_D         = rs1;
    rs2_D         = rs2;
    mult_done     = md;
    div_done      = dd;
  endtask

  task automatic idleCycle(input logic md, input logic dd);
    applyStimulus(1'b0, 1'b0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, md, dd);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    idleCycle(1'b0, 1'b0);
    nextCycle();
    rst = 1'b0;
    nextCycle();
  endtask

  // Reference decode for the XLEN=64 instance, from the instruction tables.
  task automatic refDecode(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                           output logic md, output logic dv, output logic [1:0] fn, output logic w);
    md = 1'b0; dv = 1'b0; fn = 2'b00; w = 1'b0;
    if (f7 == F7M && (opc == OPC || opc == OPC32)) begin
      w = (opc == OPC32);
      case (f3)
        3'd0: fn = 2'b00;
        3'd1: fn = 2'b01;
        3'd2: fn = 2'b11;
        3'd3: fn = 2'b10;
        3'd4: begin dv = 1'b1; fn = 2'b00; end
        3'd5: begin dv = 1'b1; fn = 2'b01; end
        3'd6: begin dv = 1'b1; fn = 2'b10; end
        default: begin dv = 1'b1; fn = 2'b11; end
      endcase
      md = !w || (f3 == 3'd0) || (f3 >= 3'd4);
    end
  endtask

  task automatic divZeroCase(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                             input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp_res);
    applyStimulus(1'b1, 1'b0, opc, f3, F7M, 5'd8, 5'd1, 5'd2, 1'b0, 1'b0);
    rs1_val_E = a;
    rs2_val_E = b;
    #1; nextCycle();
    idleCycle(1'b0, 1'b0);
    #1;
`ifdef MD_DIV0_FASTPATH_EN
    checkOutput({tag, "_start_div"}, 64'(start_div), 64'(0));
    nextCycle();
    #1;
    checkOutput({tag, "_wb_valid"}, 64'(md_wb_valid), 64'(1));
    checkOutput({tag, "_dz_valid"}, 64'(md_dz_valid), 64'(1));
    checkOutput({tag, "_dz_result"}, md_dz_result, exp_res);
    nextCycle();
`else
    checkOutput({tag, "_start_div"}, 64'(start_div), 64'(1));
    nextCycle();
    idleCycle(1'b0, 1'b1);
    #1;
    checkOutput({tag, "_dz_valid_wait"}, 64'(md_dz_valid), 64'(0));
    nextCycle();
    idleCycle(1'b0, 1'b0);
    #1;
    checkOutput({tag, "_wb_valid"}, 64'(md_wb_valid), 64'(1));
    checkOutput({tag, "_dz_valid"}, 64'(md_dz_valid), 64'(0));
    checkOutput({tag, "_dz_result"}, md_dz_result, 64'(0) & exp_res);
    nextCycle();
`endif
    #1;
    checkOutput({tag, "_idle"}, 64'(md_busy), 64'(0));
    rs1_val_E = 64'h11;
    rs2_val_E = 64'h5;
    nextCycle();
  endtask

  initial begin
    vec_t tbl[$];
    logic [RW-1:0] rd;

    checks = 0;
    fails  = 0;
    rst    = 1'b1;
    rs1_val_E = 64'h11;
    rs2_val_E = 64'h5;
    applyStimulus(1'b1, 1'b0, OPC, 3'd0, F7M, 5'd3, 5'd0, 5'd0, 1'b1, 1'b1);
    #1;
    checkOutput("rst_busy", 64'(md_busy), 64'(0));
    checkOutput("rst_stall", 64'(stall_D), 64'(0));
    checkOutput("rst_start", 64'({start_mult, start_div}), 64'(0));
    checkOutput("rst_wb", 64'({md_wb_valid, md_wb_rd}), 64'(0));
    checkOutput("rst_cnt", 64'(md_stall_cnt), 64'(0));
    checkOutput("rst_dz", 64'(md_dz_valid), 64'(0));
    nextCycle();
    rst = 1'b0;
    idleCycle(1'b0, 1'b0);
    nextCycle();

    // ---- decode table ----
    tbl.push_back('{OPC,   3'd0, F7M,   1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0});
    tbl.push_back('{OPC,   3'd1, F7M,   1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0});
    tbl.push_back('{OPC,   3'd2, F7M,   1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0});
    tbl.push_back('{OPC,   3'd3, F7M,   1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0});
    tbl.push_back('{OPC,   3'd4, F7M,   1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0});
    tbl.push_back('{OPC,   3'd5, F7M,   1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0});
    tbl.push_back('{OPC,   3'd6, F7M,   1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0});
    tbl.push_back('{OPC,   3'd7, F7M,   1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0});
    tbl.push_back('{OPC,   3'd0, 7'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0});
    tbl.push_back('{OPC,   3'd0, 7'h20, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0});
    tbl.push_back('{OPC32, 3'd0, F7M,   1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1});
    tbl.push_back('{OPC32, 3'd4, F7M,   1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1});
    tbl.push_back('{OPC32, 3'd5, F7M,   1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1});
    tbl.push_back('{OPC32, 3'd6, F7M,   1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1});
    tbl.push_back('{OPC32, 3'd7, F7M,   1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 1'b1});
    tbl.push_back('{OPC32, 3'd1, F7M,   1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0});
    tbl.push_back('{OPC32, 3'd2, F7M,   1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0});
    tbl.push_back('{OPC32, 3'd0, 7'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0});
    tbl.push_back('{7'b0010011, 3'd0, F7M, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0});
    tbl.push_back('{OPC,   3'd0, F7M,   1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0});

    foreach (tbl[i]) begin
      rd = RW'(i + 1);
      applyStimulus(1'b1, tbl[i].flush, tbl[i].opc, tbl[i].f3, tbl[i].f7, rd, 5'd1, 5'd2, 1'b0, 1'b0);
      #1;
      checkOutput("tbl_stall_idle", 64'(stall_D), 64'(0));
      nextCycle();
      idleCycle(1'b0, 1'b0);
      #1;
      checkOutput("tbl_start_mult", 64'(start_mult), 64'(tbl[i].md64 & ~tbl[i].dv));
      checkOutput("tbl_start_div", 64'(start_div), 64'(tbl[i].md64 & tbl[i].dv));
      checkOutput("tbl32_start", 64'({b_start_mult, b_start_div}),
                  64'({tbl[i].md32 & ~tbl[i].dv, tbl[i].md32 & tbl[i].dv}));
      if (tbl[i].md64 && !tbl[i].dv) checkOutput("tbl_mult_func", 64'(mult_func), 64'(tbl[i].fn));
      if (tbl[i].md64 && tbl[i].dv) checkOutput("tbl_div_func", 64'(div_func), 64'(tbl[i].fn));
      if (tbl[i].md64) checkOutput("tbl_word_op", 64'(word_op), 64'(tbl[i].word));
      if (tbl[i].md32) checkOutput("tbl32_word_op", 64'(b_word_op), 64'(0));
      nextCycle();
      idleCycle(1'b1, 1'b1);
      #1;
      checkOutput("tbl_busy", 64'(md_busy), 64'(tbl[i].md64));
      nextCycle();
      idleCycle(1'b0, 1'b0);
      #1;
      checkOutput("tbl_wb_valid", 64'(md_wb_valid), 64'(tbl[i].md64));
      checkOutput("tbl_wb_rd", 64'(md_wb_rd), tbl[i].md64 ? 64'(rd) : 64'(0));
      checkOutput("tbl32_wb_valid", 64'(b_md_wb_valid), 64'(tbl[i].md32));
      nextCycle();
      #1;
      checkOutput("tbl_idle", 64'({md_busy, b_md_busy}), 64'(0));
      nextCycle();
    end

    // ---- mul with done four cycles after accept ----
    applyStimulus(1'b1, 1'b0, OPC, 3'd0, F7M, 5'd9, 5'd1, 5'd2, 1'b0, 1'b0);
    #1; nextCycle();
    idleCycle(1'b0, 1'b0);
    #1;
    checkOutput("mul_start_n1", 64'({start_mult, start_div}), 64'(2'b10));
    checkOutput("mul_func_n1", 64'(mult_func), 64'(0));
    nextCycle();
    #1; checkOutput("mul_start_n2", 64'(start_mult), 64'(0));
    nextCycle();
    #1; checkOutput("mul_start_n3", 64'(start_mult), 64'(0));
    nextCycle();
    idleCycle(1'b1, 1'b0);
    #1; checkOutput("mul_wb_n4", 64'(md_wb_valid), 64'(0));
    nextCycle();
    idleCycle(1'b0, 1'b0);
    #1;
    checkOutput("mul_wb_n5", 64'(md_wb_valid), 64'(1));
    checkOutput("mul_wb_rd_n5", 64'(md_wb_rd), 64'(9));
    nextCycle();
    #1; checkOutput("mul_idle_n6", 64'({md_busy, md_wb_valid, md_wb_rd}), 64'(0));
    nextCycle();

    // ---- dones in ISSUE and from the wrong unit are ignored ----
    applyStimulus(1'b1, 1'b0, OPC, 3'd4, F7M, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0);
    #1; nextCycle();
    idleCycle(1'b0, 1'b1);
    #1; checkOutput("ign_start_div", 64'(start_div), 64'(1));
    nextCycle();
    idleCycle(1'b1, 1'b0);
    #1; checkOutput("ign_busy", 64'(md_busy), 64'(1));
    nextCycle();
    idleCycle(1'b0, 1'b1);
    #1; checkOutput("ign_no_wb", 64'(md_wb_valid), 64'(0));
    nextCycle();
    idleCycle(1'b0, 1'b0);
    #1; checkOutput("ign_wb", 64'({md_wb_valid, md_wb_rd}), 64'({1'b1, 5'd3}));
    nextCycle();

    // ---- RAW hazard against outstanding divu ----
    doReset();
    applyStimulus(1'b1, 1'b0, OPC, 3'd5, F7M, 5'd7, 5'd1, 5'd2, 1'b0, 1'b0);
    #1; nextCycle();
    for (int k = 1; k <= 4; k++) begin
      if (k <= 2) applyStimulus(1'b1, 1'b0, OPC, 3'd0, 7'd0, 5'd3, 5'd7, 5'd1, 1'b0, 1'b0);
      else        applyStimulus(1'b1, 1'b0, OPC, 3'd0, 7'd0, 5'd3, 5'd1, 5'd7, 1'b0, k == 4);
      #1; checkOutput("raw_stall", 64'(stall_D), 64'(1));
      nextCycle();
    end
    applyStimulus(1'b1, 1'b0, OPC, 3'd0, 7'd0, 5'd3, 5'd1, 5'd7, 1'b0, 1'b0);
    #1;
    checkOutput("raw_stall_wb", 64'(stall_D), 64'(0));
    checkOutput("raw_wb_rd", 64'({md_wb_valid, md_wb_rd}), 64'({1'b1, 5'd7}));
    nextCycle();
    idleCycle(1'b0, 1'b0);
    #1; checkOutput("raw_cnt", 64'(md_stall_cnt), 64'(4));
    nextCycle();
    applyStimulus(1'b1, 1'b0, OPC, 3'd4, F7M, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
    #1; nextCycle();
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b1, 1'b0, OPC, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 1'b0, k == 3);
      #1; checkOutput("x0_no_stall", 64'(stall_D), 64'(0));
      nextCycle();
    end
    idleCycle(1'b0, 1'b0);
    #1; checkOutput("x0_wb", 64'({md_wb_valid, md_wb_rd}), 64'({1'b1, 5'd0}));
    nextCycle();
    #1; checkOutput("x0_cnt", 64'(md_stall_cnt), 64'(4));
    nextCycle();

    // ---- structural stall: second mulh waits through WB ----
    doReset();
    applyStimulus(1'b1, 1'b0, OPC, 3'd0, F7M, 5'd4, 5'd1, 5'd2, 1'b0, 1'b0);
    #1; nextCycle();
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 1'b0, OPC, 3'd1, F7M, 5'd5, 5'd1, 5'd2, k == 3, 1'b0);
      #1; checkOutput("struct_stall", 64'(stall_D), 64'(1));
      if (k == 4) checkOutput("struct_wb", 64'({md_wb_valid, md_wb_rd}), 64'({1'b1, 5'd4}));
      nextCycle();
    end
    applyStimulus(1'b1, 1'b0, OPC, 3'd1, F7M, 5'd5, 5'd1, 5'd2, 1'b0, 1'b0);
    #1;
    checkOutput("struct_release", 64'({stall_D, md_busy}), 64'(0));
    checkOutput("struct_cnt", 64'(md_stall_cnt), 64'(4));
    nextCycle();
    idleCycle(1'b0, 1'b0);
    #1;
    checkOutput("struct_start2", 64'(start_mult), 64'(1));
    checkOutput("struct_func2", 64'(mult_func), 64'(2'b01));
    nextCycle();
    idleCycle(1'b1, 1'b0);
    #1; nextCycle();
    idleCycle(1'b0, 1'b0);
    #1; checkOutput("struct_wb2", 64'({md_wb_valid, md_wb_rd}), 64'({1'b1, 5'd5}));
    nextCycle();

    // ---- asynchronous reset while waiting on the divider ----
    applyStimulus(1'b1, 1'b0, OPC, 3'd4, F7M, 5'd6, 5'd1, 5'd2, 1'b0, 1'b0);
    #1; nextCycle();
    idleCycle(1'b0, 1'b0);
    #1; nextCycle();
    applyStimulus(1'b1, 1'b0, OPC, 3'd0, 7'd0, 5'd3, 5'd6, 5'd1, 1'b0, 1'b0);
    #1; checkOutput("rstw_stall_pre", 64'(stall_D), 64'(1));
    rst = 1'b1;
    #1;
    checkOutput("rstw_busy", 64'({md_busy, stall_D, start_div, div_func}), 64'(0));
    checkOutput("rstw_wb", 64'({md_wb_valid, md_wb_rd}), 64'(0));
    checkOutput("rstw_cnt", 64'(md_stall_cnt), 64'(0));
    nextCycle();
    rst = 1'b0;
    idleCycle(1'b0, 1'b1);
    #1; checkOutput("rstw_late_done", 64'(md_wb_valid), 64'(0));
    nextCycle();
    idleCycle(1'b0, 1'b0);
    #1; checkOutput("rstw_after", 64'({md_wb_valid, md_busy}), 64'(0));
    nextCycle();

    // ---- divide by zero ----
    divZeroCase("dz_rem", OPC, 3'd6, 64'h1234, 64'h0, 64'h1234);
    divZeroCase("dz_divu", OPC, 3'd5, 64'h55, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    divZeroCase("dz_remw", OPC32, 3'd6, 64'h0000_0000_8000_1234, 64'hFFFF_FFFF_0000_0000,
                64'hFFFF_FFFF_8000_1234);

    // ---- randomized run against a timeline model ----
    doReset();
    begin
      logic m_valid, m_div, m_word;
      logic [1:0] m_func;
      logic [RW-1:0] m_rd;
      int m_acc, m_done;
      longint m_cnt;
      logic r_md, r_dv, r_w;
      logic [1:0] r_fn;
      logic v, fl, busy, in_wb, issue, exp_stall;
      logic [6:0] opc, f7;
      logic [2:0] f3;
      logic [RW-1:0] rd_r, rs1_r, rs2_r;
      logic mdn, ddn;

      m_valid = 1'b0; m_div = 1'b0; m_word = 1'b0; m_func = 2'b00; m_rd = '0;
      m_acc = 0; m_done = -1; m_cnt = 0;
      for (int t = 0; t < 800; t++) begin
        v  = ($urandom_range(0, 3) != 0);
        fl = ($urandom_range(0, 7) == 0);
        case ($urandom_range(0, 5))
          0, 1, 2: begin opc = OPC;   f7 = F7M;  end
          3:       begin opc = OPC32; f7 = F7M;  end
          4:       begin opc = OPC;   f7 = 7'd0; end
          default: begin opc = OPC32; f7 = 7'd0; end
        endcase
        f3    = 3'($urandom_range(0, 7));
        rd_r  = RW'($urandom_range(0, 7));
        rs1_r = RW'($urandom_range(0, 7));
        rs2_r = RW'($urandom_range(0, 7));
        mdn   = ($urandom_range(0, 3) == 0);
        ddn   = ($urandom_range(0, 3) == 0);
        applyStimulus(v, fl, opc, f3, f7, rd_r, rs1_r, rs2_r, mdn, ddn);
        rs1_val_E = {32'($urandom), 32'($urandom)};
        rs2_val_E = {32'($urandom), 32'($urandom)} | 64'h1;
        refDecode(opc, f3, f7, r_md, r_dv, r_fn, r_w);

        busy      = m_valid;
        in_wb     = m_valid && (m_done >= 0) && (t == m_done + 1);
        issue     = m_valid && (t == m_acc + 1);
        exp_stall = v && busy && (r_md || ((m_rd != '0) && ((rs1_r == m_rd) || (rs2_r == m_rd)) && !in_wb));
        #1;
        checkOutput("rnd_busy", 64'(md_busy), 64'(busy));
        checkOutput("rnd_start", 64'({start_mult, start_div}), 64'({issue && !m_div, issue && m_div}));
        checkOutput("rnd_stall", 64'(stall_D), 64'(exp_stall));
        checkOutput("rnd_wb", 64'({md_wb_valid, md_wb_rd}), 64'({in_wb, in_wb ? m_rd : 5'd0}));
        checkOutput("rnd_cnt", 64'(md_stall_cnt), 64'(m_cnt));
        if (busy) begin
          checkOutput("rnd_func", 64'(m_div ? div_func : mult_func), 64'(m_func));
          checkOutput("rnd_word", 64'(word_op), 64'(m_word));
        end
        if (exp_stall) m_cnt++;
        if (m_valid && (t >= m_acc + 2) && (m_done < 0) && (m_div ? ddn : mdn)) m_done = t;
        if (in_wb) m_valid = 1'b0;
        if (!busy && v && r_md && !fl) begin
          m_valid = 1'b1; m_acc = t; m_done = -1;
          m_div = r_dv; m_func = r_fn; m_word = r_w; m_rd = rd_r;
        end
        nextCycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
